// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Purpose:
//   8N1 asynchronous serial receiver. The raw pin is brought into the clk
//   domain through a two-flop synchronizer. A start bit is validated at its
//   midpoint, then eight data bits are sampled LSB-first at mid-bit. The stop
//   bit is checked at its midpoint. Good bytes are queued in a small
//   first-word-fall-through FIFO whose head is always visible on rx_data.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   uart_rx    in   serial line (idle high), asynchronous to clk
//   rx_pop     in   one-cycle pulse: dequeue the FIFO head (ignored when empty)
//   err_clr    in   one-cycle pulse: clear the sticky overrun / frame_err flags
//   rx_data    out  FIFO head byte while rx_valid, otherwise 0
//   rx_valid   out  FIFO non-empty
//   rx_count   out  FIFO occupancy
//   overrun    out  sticky: a good byte was dropped because the FIFO was full
//   frame_err  out  sticky: a byte was dropped because its stop bit was 0
//   rx_busy    out  receive FSM is not idle
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  input  logic                          rx_pop,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          rx_busy
);

  localparam int BCNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW     = $clog2(FIFO_DEPTH);

  // Mid-start-bit compare point and the full-bit terminal count.
  localparam logic [BCNT_W-1:0] HALF_M1 = BCNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCNT_W-1:0] FULL_M1 = BCNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both stages reset high so a reset never looks like a
  // falling edge on the line.
  // ---------------------------------------------------------------------------
  logic [1:0] r_sync;
  logic       w_rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], uart_rx};
    end
  end

  assign w_rx_s = r_sync[1];

  // ---------------------------------------------------------------------------
  // Receive FSM: state register process
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;

  state_t              w_state_next;
  logic [BCNT_W-1:0]   w_bcnt_next;
  logic [2:0]          w_bit_idx_next;
  logic [7:0]          w_shift_next;
  logic                w_stop_sample;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bcnt    <= w_bcnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM: next-state / datapath process
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_bcnt_next    = r_bcnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_stop_sample  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = S_START;
          w_bcnt_next  = '0;
        end
      end

      S_START: begin
        if (r_bcnt == HALF_M1) begin
          // A line that is high again at mid-start-bit was only a glitch.
          if (w_rx_s) begin
            w_state_next = S_IDLE;
          end else begin
            // From here on every full-bit tick lands at the middle of a bit.
            w_state_next   = S_DATA;
            w_bcnt_next    = '0;
            w_bit_idx_next = '0;
          end
        end else begin
          w_bcnt_next = r_bcnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_bcnt == FULL_M1) begin
          w_shift_next[r_bit_idx] = w_rx_s;
          w_bcnt_next             = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_bcnt_next = r_bcnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_bcnt == FULL_M1) begin
          // Leave at mid-stop so a start bit that immediately follows the
          // stop bit is seen without losing half a bit of margin.
          w_stop_sample = 1'b1;
          w_state_next  = S_IDLE;
          w_bcnt_next   = '0;
        end else begin
          w_bcnt_next = r_bcnt + 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign rx_busy = (r_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Receive FIFO. Pointers carry one extra wrap bit so full and empty are
  // distinguishable with all entries usable.
  // ---------------------------------------------------------------------------
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_overrun_set;
  logic w_frame_set;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop         = rx_pop && !w_empty;
  assign w_push_req    = w_stop_sample && w_rx_s;
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // accepts the byte; the write lands in the slot being vacated.
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_overrun_set = w_push_req && w_full && !w_pop;
  assign w_frame_set   = w_stop_sample && !w_rx_s;

  // Storage has no reset; stale contents are never visible because the head
  // output is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_shift_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // The head is read combinationally so a popped entry is replaced by the
  // next one on the very next cycle (first-word fall-through).
  assign rx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign rx_valid = !w_empty;
  assign rx_count = r_wr_ptr - r_rd_ptr;

  // ---------------------------------------------------------------------------
  // Sticky error flags; a set event in the same cycle as err_clr wins.
  // ---------------------------------------------------------------------------
  logic r_overrun;
  logic r_frame_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Purpose:
//   Self-checking bench for uart_receiver with CLKS_PER_BIT=16, FIFO_DEPTH=4.
//   Sent bytes that should be accepted are pushed onto a scoreboard queue when
//   the frame is driven and compared when the DUT presents them on rx_data.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       rx_pop;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rx_pop    (rx_pop),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; returns at the
  // falling edge that ends the stop bit, line high again.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Good frame; the byte is expected only if the model FIFO has room.
  task automatic send_and_expect(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    $display("send byte 0x%02h", b);
    send_frame(b, 1'b1);
  endtask

  // Waits (bounded) for a byte, compares it with the scoreboard, pops it.
  task automatic drain_one();
    int n;
    n = 0;
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid) begin
      check("drain_timeout_valid", {31'd0, rx_valid}, 32'd1);
    end else begin
      if (exp_q.size() == 0) begin
        check("scoreboard_size", 32'(exp_q.size()), 32'd1);
      end else begin
        $display("recv byte 0x%02h", rx_data);
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   valid_cyc;
    int   busy_cyc;
    logic seen_busy;

    rst_n   = 1'b0;
    uart_rx = 1'b1;
    rx_pop  = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
    check("rst_rx_data",   {24'd0, rx_data},   32'd0);
    check("rst_rx_count",  {29'd0, rx_count},  32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_rx_busy",   {31'd0, rx_busy},   32'd0);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // ---- single frame: latency, head, pop ----
    valid_cyc = -1;
    busy_cyc  = -1;
    fork
      send_and_expect(8'hA5);
      begin
        for (int n = 1; n <= 400; n++) begin
          @(posedge clk);
          #1;
          if (rx_busy && busy_cyc < 0) busy_cyc = n;
          if (rx_valid) begin
            valid_cyc = n;
            break;
          end
        end
      end
    join
    check("busy_latency",  32'(busy_cyc),  32'd3);
    check("valid_latency", 32'(valid_cyc), 32'(3 + CPB / 2 + 9 * CPB));
    check("a5_count",      {29'd0, rx_count}, 32'd1);
    drain_one();
    check("pop_valid", {31'd0, rx_valid}, 32'd0);
    check("pop_data",  {24'd0, rx_data},  32'd0);

    // ---- 16 back-to-back frames, drained as they arrive ----
    fork
      begin
        for (int i = 0; i < 16; i++) send_and_expect(8'(i * 17));
      end
      begin
        for (int i = 0; i < 16; i++) drain_one();
      end
    join
    check("b2b_overrun",   {31'd0, overrun},   32'd0);
    check("b2b_frame_err", {31'd0, frame_err}, 32'd0);
    check("b2b_empty",     {31'd0, rx_valid},  32'd0);

    // ---- overrun: 5 frames, no pops ----
    for (int i = 1; i <= 5; i++) send_and_expect(8'(8'h30 + i));
    check("ovr_count",     {29'd0, rx_count},  32'd4);
    check("ovr_flag",      {31'd0, overrun},   32'd1);
    check("ovr_head",      {24'd0, rx_data},   {24'd0, exp_q[0]});
    check("ovr_frame_err", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < 4; i++) drain_one();
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    pulse_err_clr();
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // ---- framing error then a good frame ----
    $display("send byte 0x3c (stop bit 0)");
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_flag",  {31'd0, frame_err}, 32'd1);
    check("ferr_valid", {31'd0, rx_valid},  32'd0);
    check("ferr_busy",  {31'd0, rx_busy},   32'd0);
    send_and_expect(8'h5A);
    drain_one();
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);
    pulse_err_clr();
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // ---- short glitch on the line ----
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    seen_busy = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rx_busy) seen_busy = 1'b1;
    end
    check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
    check("glitch_idle",      {31'd0, rx_busy},   32'd0);
    check("glitch_no_push",   {31'd0, rx_valid},  32'd0);
    check("glitch_no_ferr",   {31'd0, frame_err}, 32'd0);
    check("glitch_no_ovr",    {31'd0, overrun},   32'd0);

    // ---- reset in the middle of a frame ----
    send_and_expect(8'h99);
    fork
      begin
        $display("send byte 0x77 (reset mid-frame)");
        send_frame(8'h77, 1'b1);
      end
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
      end
    join
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_valid",  {31'd0, rx_valid},  32'd0);
    check("mid_rst_data",   {24'd0, rx_data},   32'd0);
    check("mid_rst_count",  {29'd0, rx_count},  32'd0);
    check("mid_rst_busy",   {31'd0, rx_busy},   32'd0);
    check("mid_rst_ferr",   {31'd0, frame_err}, 32'd0);
    send_and_expect(8'h12);
    drain_one();
    check("mid_rst_only_one", {29'd0, rx_count}, 32'd0);

    // ---- full FIFO with a pop on the stop-sample edge ----
    for (int i = 1; i <= 4; i++) send_and_expect(8'(8'hC0 + i));
    check("full_count", {29'd0, rx_count}, 32'd4);
    exp_q.push_back(8'hC5);
    fork
      begin
        $display("send byte 0xc5");
        send_frame(8'hC5, 1'b1);
      end
      begin
        repeat (3 + CPB / 2 + 9 * CPB - 1) @(posedge clk);
        @(negedge clk);
        $display("recv byte 0x%02h", rx_data);
        check("full_pop_head", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
      end
    join
    check("full_pop_count",   {29'd0, rx_count}, 32'd4);
    check("full_pop_overrun", {31'd0, overrun},  32'd0);
    for (int i = 0; i < 4; i++) drain_one();
    check("full_pop_empty", {31'd0, rx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

8N1 asynchronous serial receiver: the receive-side counterpart of the SoC's UART transmit path, instantiated inside the IO block next to the existing TX logic. It synchronizes the `uart_rx` pin, detects and validates start bits, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and queues good bytes in a small first-word-fall-through FIFO. The IO block maps `rx_data`/status onto MMIO read registers and drives `rx_pop`/`err_clr` from MMIO accesses.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Must be ≥ 8 and even.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `uart_rx`  in  1  serial line from pin; idle high; asynchronous to `clk`.
- `rx_pop`  in  1  one-cycle pulse: dequeue FIFO head (MMIO read of RX data register).
- `err_clr`  in  1  one-cycle pulse: clear sticky `overrun` and `frame_err`.
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid`=1; 0 when empty.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overrun`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a byte was dropped because its stop bit sampled 0.
- `rx_busy`  out  1  FSM not in IDLE.

## Operation
- Synchronizer: 2 flops on `uart_rx`, both reset to 1. The FSM sees only the second flop (`rx_s`).
- Baud counter `bcnt` counts 0..CLKS_PER_BIT-1. A "tick" is `bcnt` == terminal value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rx_s`=0, go to START with `bcnt`=0.
  - START: at `bcnt` = CLKS_PER_BIT/2-1 (mid start bit), sample `rx_s`.
    - If 1 (glitch): return to IDLE; nothing else changes.
    - If 0: go to DATA with `bcnt`=0 and bit index 0.
  - DATA: on each tick, shift `rx_s` into bit [index] (LSB first) and reset `bcnt`. After bit 7, go to STOP.
  - STOP: on tick, sample `rx_s`.
    - If 1: push the byte into the FIFO. If the FIFO is full and there is no simultaneous pop, drop the byte and set `overrun`.
    - If 0: drop the byte and set `frame_err`.
    - In both cases go to IDLE immediately (at mid-stop), so a back-to-back start bit is caught.
- FIFO: circular buffer with read/write pointers one bit wider than the index. Full when the MSBs differ and the index bits are equal.
  - `rx_data` = mem[rd_ptr] when non-empty, else 0.
  - `rx_pop` while empty is ignored; pointers are unchanged.
  - Simultaneous push and pop: both happen. This is also true when full, so no overrun is flagged and the count is unchanged.
- Sticky flags: if `err_clr` and a set event occur in the same cycle, the set wins.

## Timing
- Reset (`rst_n`=0 at a posedge):
  - FSM goes to IDLE and pointers go to 0.
  - `rx_data`=0, `rx_valid`=0, `rx_count`=0, `overrun`=0, `frame_err`=0, `rx_busy`=0. Sync flops go to 1.
  - A frame in progress is abandoned with no partial push.
  - After reset release, a line already low enters START on the first cycle `rx_s`=0.
- Pin fall to START entry: 3 cycles (2 sync stages + IDLE compare). `rx_busy` rises on that edge.
- Data bit k is sampled CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT cycles after START entry.
- Stop sample occurs CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after START entry. On the same edge:
  - `rx_valid`/`rx_count` update (push), or `overrun`/`frame_err` are set.
  - `rx_busy` falls.
- Pop: `rx_data` shows the next entry, or 0, on the cycle after `rx_pop`.
- Throughput: continuous back-to-back frames at the nominal rate with no loss while the FIFO is drained. The receiver tolerates ±4% baud mismatch.

## Test plan
- With CLKS_PER_BIT=16, drive frame 0xA5 → `rx_valid`=1 exactly 3+8+144 cycles after the pin falls, `rx_data`=0xA5 and `rx_count`=1. `rx_pop` gives `rx_valid`=0 and `rx_data`=0 next cycle.
- Send 16 back-to-back frames with values 0x00, 0x11, …, 0xFF, popping each after it arrives → all 16 bytes are received in order, `overrun`=0 and `frame_err`=0.
- Send 5 frames with no pops (depth 4) → `rx_count`=4, `overrun`=1, and the head is the 1st byte. After 4 pops the bytes read back are frames 1–4, and `overrun` stays 1 until `err_clr`.
- Send frame 0x3C with the stop bit held 0 → no push, `frame_err`=1. The next good frame 0x5A is received normally.
- Pulse the line low for 4 cycles (less than half a bit) → `rx_busy` pulses, then the FSM returns to IDLE with no push and no error.
- Assert reset during DATA of frame 0x77, then release and send 0x12 → after reset all outputs are 0, and only 0x12 is received. Also, while the FIFO is full, issue a pop on the same cycle as the stop sample → count stays 4 and `overrun`=0.
